// File: rtl/regfile_writeback_pkg.sv
// Shared widths and the writeback record for the register-file write driver.
package regfile_writeback_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_rec_t;

endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// Parameterised synchronous FIFO for buffered load returns.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata_c,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign w_do_push = i_push && !o_full_c;
  assign w_do_pop  = i_pop && !o_empty_c;
  assign o_rdata_c = r_mem[r_rptr];

  // Storage is data-only; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write driver: ALU results take priority, queued load returns
// drain on free cycles, and a busy scoreboard tracks outstanding loads.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_wb_valid,
  input  logic [ADDR_W-1:0]   alu_wb_rd,
  input  logic [DATA_W-1:0]   alu_wb_data,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_W-1:0]   ld_rd,
  input  logic [DATA_W-1:0]   ld_data,
  output logic [ADDR_W-1:0]   rd,
  output logic [DATA_W-1:0]   write_data,
  output logic                reg_write,
  output logic [NUM_REGS-1:0] busy,
  output logic                waw_error
);

  logic [ADDR_W-1:0]   r_rd;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic [NUM_REGS-1:0] r_busy;
  logic                r_waw;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_alu_wr;
  wb_rec_t             w_head;
  wb_rec_t             w_ld_rec;
  logic [NUM_REGS-1:0] w_busy_nxt;

  assign ld_ready   = !w_full;
  assign w_alu_wr   = alu_wb_valid && (alu_wb_rd != '0);
  // Returns to x0 are accepted but never stored.
  assign w_push     = ld_valid && ld_ready && (ld_rd != '0);
  assign w_pop      = !w_alu_wr && !w_empty;
  assign w_ld_rec   = '{rd: ld_rd, data: ld_data};

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(wb_rec_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_wdata   (w_ld_rec),
    .i_pop     (w_pop),
    .o_rdata_c (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty)
  );

  // Scoreboard update: a same-edge issue overrides the pop clear.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) w_busy_nxt[w_head.rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) w_busy_nxt[issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_busy  <= '0;
      r_waw   <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_alu_wr && r_busy[alu_wb_rd]) r_waw <= 1'b1;
      if (w_alu_wr) begin
        r_rd    <= alu_wb_rd;
        r_wdata <= alu_wb_data;
        r_we    <= 1'b1;
      end else if (w_pop) begin
        r_rd    <= w_head.rd;
        r_wdata <= w_head.data;
        r_we    <= 1'b1;
      end else begin
        r_we    <= 1'b0;
      end
    end
  end

  assign rd         = r_rd;
  assign write_data = r_wdata;
  assign reg_write  = r_we;
  assign busy       = r_busy;
  assign waw_error  = r_waw;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: vector table plus corner sequences.
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic              clk;
  logic              rst_n;
  logic              alu_wb_valid;
  logic [ADDR_W-1:0] alu_wb_rd;
  logic [DATA_W-1:0] alu_wb_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  logic [31:0]       busy;
  logic              waw_error;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rd(rd), .write_data(write_data), .reg_write(reg_write),
    .busy(busy), .waw_error(waw_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        ld_v;
    logic [4:0]  ld_rd;
    logic [31:0] ld_d;
    logic        exp_we;
    logic [4:0]  exp_rd;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  wb_rec_t     m_fifo[$];
  wb_rec_t     exp_q[$];
  logic [31:0] m_busy;
  logic        m_waw;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  function automatic vec_t mk(bit av, int ard, logic [31:0] ad, bit iv, int ird,
                              bit lv, int lrd, logic [31:0] ldd, bit we, int wrd);
    vec_t v;
    v.alu_v = av;  v.alu_rd = 5'(ard); v.alu_d = ad;
    v.iss_v = iv;  v.iss_rd = 5'(ird);
    v.ld_v  = lv;  v.ld_rd  = 5'(lrd); v.ld_d  = ldd;
    v.exp_we = we; v.exp_rd = 5'(wrd);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_busy = '0;
    m_waw  = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  function automatic vec_t idle();
    return mk(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
  endfunction

  // Drive one cycle, update the model, and score DUT outputs after the edge.
  task automatic cycle(input vec_t v);
    bit          alu_wr;
    bit          ready;
    wb_rec_t     e;
    wb_rec_t     got;
    logic [31:0] nb;
    alu_wb_valid = v.alu_v; alu_wb_rd = v.alu_rd; alu_wb_data = v.alu_d;
    issue_valid  = v.iss_v; issue_rd  = v.iss_rd;
    ld_valid     = v.ld_v;  ld_rd     = v.ld_rd;  ld_data     = v.ld_d;
    ready  = (m_fifo.size() < DEPTH);
    chk("ld_ready", 32'(ld_ready), 32'(ready));
    alu_wr = v.alu_v && (v.alu_rd != 0);
    if (alu_wr && m_busy[v.alu_rd]) m_waw = 1'b1;
    nb = m_busy;
    if (alu_wr) begin
      e.rd = v.alu_rd; e.data = v.alu_d;
      exp_q.push_back(e);
    end else if (m_fifo.size() > 0) begin
      e = m_fifo.pop_front();
      nb[e.rd] = 1'b0;
      exp_q.push_back(e);
    end
    if (v.ld_v && ready && v.ld_rd != 0) begin
      e.rd = v.ld_rd; e.data = v.ld_d;
      m_fifo.push_back(e);
    end
    if (v.iss_v && v.iss_rd != 0) nb[v.iss_rd] = 1'b1;
    nb[0] = 1'b0;
    m_busy = nb;
    @(posedge clk); #1;
    if (reg_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(reg_write), 32'd0);
      end else begin
        got = exp_q.pop_front();
        m_rd = got.rd; m_data = got.data;
        chk("reg_write", 32'(reg_write), 32'd1);
      end
    end else if (exp_q.size() != 0) begin
      got = exp_q.pop_front();
      m_rd = got.rd; m_data = got.data;
      chk("missing_write", 32'(reg_write), 32'd1);
    end else begin
      chk("reg_write", 32'(reg_write), 32'd0);
    end
    chk("rd", 32'(rd), 32'(m_rd));
    chk("write_data", write_data, m_data);
    chk("busy", busy, m_busy);
    chk("waw_error", 32'(waw_error), 32'(m_waw));
  endtask

  vec_t tbl[17];

  initial begin
    rst_n = 1'b0;
    alu_wb_valid = 0; alu_wb_rd = '0; alu_wb_data = '0;
    issue_valid = 0; issue_rd = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0;
    model_reset();

    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0,    1, 5);
    tbl[1]  = mk(1, 0, 32'h00000055, 0, 0, 0, 0, 32'h0,    0, 5);
    tbl[2]  = mk(0, 0, 32'h0,        1, 7, 0, 0, 32'h0,    0, 5);
    tbl[3]  = mk(0, 0, 32'h0,        0, 0, 1, 7, 32'h1234, 0, 5);
    tbl[4]  = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    1, 7);
    tbl[5]  = mk(1, 10, 32'hA0,      0, 0, 1, 1, 32'h11,   1, 10);
    tbl[6]  = mk(1, 11, 32'hA1,      0, 0, 1, 2, 32'h22,   1, 11);
    tbl[7]  = mk(1, 12, 32'hA2,      0, 0, 1, 3, 32'h33,   1, 12);
    tbl[8]  = mk(1, 13, 32'hA3,      0, 0, 1, 4, 32'h44,   1, 13);
    tbl[9]  = mk(1, 14, 32'hA4,      0, 0, 1, 5, 32'h55,   1, 14);
    tbl[10] = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    1, 1);
    tbl[11] = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    1, 2);
    tbl[12] = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    1, 3);
    tbl[13] = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    1, 4);
    tbl[14] = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    0, 4);
    tbl[15] = mk(0, 0, 32'h0,        0, 0, 1, 0, 32'h99,   0, 4);
    tbl[16] = mk(0, 0, 32'h0,        0, 0, 0, 0, 32'h0,    0, 4);

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_waw", 32'(waw_error), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);

    foreach (tbl[i]) begin
      cycle(tbl[i]);
      chk($sformatf("tbl%0d_we", i), 32'(reg_write), 32'(tbl[i].exp_we));
      chk($sformatf("tbl%0d_rd", i), 32'(rd), 32'(tbl[i].exp_rd));
    end

    // Issue to x3 on the same edge its queued load pops: busy stays set.
    cycle(mk(0, 0, 32'h0, 1, 3, 0, 0, 32'h0, 0, 0));
    cycle(mk(0, 0, 32'h0, 0, 0, 1, 3, 32'h333, 0, 0));
    cycle(mk(0, 0, 32'h0, 1, 3, 0, 0, 32'h0, 0, 0));
    chk("same_edge_write_rd", 32'(rd), 32'd3);
    chk("same_edge_busy3", 32'(busy[3]), 32'd1);
    cycle(mk(0, 0, 32'h0, 0, 0, 1, 3, 32'h3333, 0, 0));
    cycle(idle());
    chk("busy3_cleared", 32'(busy[3]), 32'd0);

    // ALU write to a register with an outstanding load.
    cycle(mk(0, 0, 32'h0, 1, 9, 0, 0, 32'h0, 0, 0));
    cycle(mk(1, 9, 32'h9999, 0, 0, 0, 0, 32'h0, 0, 0));
    chk("waw_set", 32'(waw_error), 32'd1);
    chk("waw_write_proceeds", write_data, 32'h9999);
    cycle(idle());
    cycle(idle());
    chk("waw_sticky", 32'(waw_error), 32'd1);
    cycle(mk(0, 0, 32'h0, 0, 0, 1, 9, 32'h9, 0, 0));
    cycle(idle());

    // Mid-run reset with three queued loads and busy = 0x90.
    cycle(mk(0, 0, 32'h0, 1, 4, 0, 0, 32'h0, 0, 0));
    cycle(mk(0, 0, 32'h0, 1, 7, 0, 0, 32'h0, 0, 0));
    cycle(mk(1, 20, 32'h20, 0, 0, 1, 4, 32'h4, 0, 0));
    cycle(mk(1, 21, 32'h21, 0, 0, 1, 7, 32'h7, 0, 0));
    cycle(mk(1, 22, 32'h22, 0, 0, 1, 8, 32'h8, 0, 0));
    chk("pre_rst_busy", busy, 32'h0000_0090);
    alu_wb_valid = 0; issue_valid = 0; ld_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_reg_write", 32'(reg_write), 32'd0);
    chk("mid_rst_rd", 32'(rd), 32'd0);
    chk("mid_rst_write_data", write_data, 32'd0);
    chk("mid_rst_busy", busy, 32'd0);
    chk("mid_rst_waw", 32'(waw_error), 32'd0);
    chk("mid_rst_ld_ready", 32'(ld_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    repeat (4) cycle(idle());
    chk("post_rst_no_write", 32'(reg_write), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
